controller_ram_burst_reader: RTL

//  Avalon-MM read master directly upstream of the controller on-chip RAM (4096 x 32, single port, 1-cycle read latency).

---
 rtl/controller_ram_burst_reader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/controller_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : controller_ram_burst_reader
// Summary  : Avalon-MM burst read master for the controller RAM. It streams
//            RAM words out on a valid/ready port through a 2-entry buffer.
// Options  : CONTROLLER_RAM_RDR_CHECKSUM_EN builds the running word checksum.
// Revision : 1.0
// ============================================================================
module controller_ram_burst_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              done_q;
    logic              clken_q;

    logic              inflight_q;
    logic              inflight_last_q;

    logic              head_valid_q;
    logic              head_last_q;
    logic [DATA_W-1:0] head_data_q;
    logic              skid_valid_q;
    logic              skid_last_q;
    logic [DATA_W-1:0] skid_data_q;

    logic              w_accept;
    logic              w_pop;
    logic [1:0]        w_occupancy;
    logic              w_issue;
    logic              w_issue_last;

    assign w_accept     = cmd_valid && (state_q == ST_IDLE);
    assign w_pop        = head_valid_q && out_ready;
    // Words already buffered plus the one returning from the RAM this cycle.
    assign w_occupancy  = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
    assign w_issue      = (state_q == ST_RUN) && ((w_occupancy - 2'(w_pop)) < 2'd2);
    assign w_issue_last = w_issue && (remain_q == LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            clken_q  <= 1'b0;
        end else begin
            clken_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        remain_q <= cmd_len;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == LEN_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && head_last_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= w_issue;
            inflight_last_q <= w_issue_last;
        end
    end

    // Head slot drives the output port; the skid slot only fills while the
    // head is stalled, which the issue rule guarantees it has room for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            head_last_q  <= 1'b0;
            head_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else if (w_pop) begin
            if (skid_valid_q) begin
                head_data_q <= skid_data_q;
                head_last_q <= skid_last_q;
                if (inflight_q) begin
                    skid_data_q <= ram_readdata;
                    skid_last_q <= inflight_last_q;
                end else begin
                    skid_valid_q <= 1'b0;
                    skid_last_q  <= 1'b0;
                end
            end else if (inflight_q) begin
                head_data_q <= ram_readdata;
                head_last_q <= inflight_last_q;
            end else begin
                head_valid_q <= 1'b0;
                head_last_q  <= 1'b0;
            end
        end else if (inflight_q) begin
            if (!head_valid_q) begin
                head_valid_q <= 1'b1;
                head_data_q  <= ram_readdata;
                head_last_q  <= inflight_last_q;
            end else begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= ram_readdata;
                skid_last_q  <= inflight_last_q;
            end
        end
    end

`ifdef CONTROLLER_RAM_RDR_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (w_accept) begin
            sum_q <= '0;
        end else if (w_pop) begin
            sum_q <= sum_q + head_data_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign cmd_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign ram_address    = addr_q;
    assign ram_chipselect = w_issue;
    assign ram_write      = 1'b0;
    assign ram_byteenable = 4'hF;
    assign ram_clken      = clken_q;
    assign out_valid      = head_valid_q;
    assign out_data       = head_data_q;
    assign out_last       = head_last_q;

endmodule
`default_nettype wire
